unidade_controle_fsm: RTL and testbench

Multicycle sequencing controller for the 16-bit processor datapath. It replaces the per-instruction control decode with an explicit FETCH/DECODE/EXEC/WRITEBACK state machine. It drives the PC-write, IR-write, ALU operand-select, ALU-op and register-write strobes, and adds a ready handshake toward instruction memory so fetch can stall. It sits between the instruction register (opcode source) and the datapath muxes, ALU, PC and register bank.

---
 rtl/unidade_controle_fsm_if.sv | 31 +++
 rtl/unidade_controle_fsm.sv | 139 +++++++++++++
 tb/tb_unidade_controle_fsm.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_fsm_if.sv
// Control bundle between the sequencing controller and the 16-bit datapath.
// master = controller side, slave = datapath / instruction memory side.
interface unidade_controle_fsm_if;
   logic [3:0] opcode;
   logic       mem_ready;
   logic       zero;
   logic       mem_req;
   logic       esc_ir;
   logic       esc_cp;
   logic       esc_cond_cp;
   logic [1:0] fonte_cp;
   logic       ula_a;
   logic [1:0] ula_b;
   logic [3:0] ula_op;
   logic       esc_reg;
   logic       flag_imm;
   logic       instr_done;
   logic       halted;

   modport master (
      input  opcode, mem_ready, zero,
      output mem_req, esc_ir, esc_cp, esc_cond_cp, fonte_cp, ula_a, ula_b,
             ula_op, esc_reg, flag_imm, instr_done, halted
   );

   modport slave (
      output opcode, mem_ready, zero,
      input  mem_req, esc_ir, esc_cp, esc_cond_cp, fonte_cp, ula_a, ula_b,
             ula_op, esc_reg, flag_imm, instr_done, halted
   );
endinterface

// File: rtl/unidade_controle_fsm.sv
// Multicycle FETCH/DECODE/EXEC/WRITEBACK sequencer for the 16-bit datapath.
// Optional PERF_COUNTER_EN adds instr_count / stall_count performance counters.
module unidade_controle_fsm #(
   parameter logic [3:0] OP_SUB  = 4'd1,
   parameter logic [3:0] OP_HALT = 4'd15
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   unidade_controle_fsm_if.master  bus
`ifdef PERF_COUNTER_EN
   ,
   output logic [15:0]             instr_count,
   output logic [15:0]             stall_count
`endif
);

   localparam logic [3:0] OP_LAST_ALU = 4'd10;
   localparam logic [3:0] OP_IMM_LO   = 4'd6;
   localparam logic [3:0] OP_BEQ      = 4'd11;
   localparam logic [3:0] OP_BNE      = 4'd12;
   localparam logic [3:0] OP_J        = 4'd13;
   localparam logic [3:0] OP_NOP      = 4'd14;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, WRITEBACK, BRANCH, JUMP, HALT
   } state_t;

   state_t state, state_nxt;

   logic       mem_req, esc_ir, esc_cp, esc_cond_cp;
   logic [1:0] fonte_cp;
   logic       ula_a;
   logic [1:0] ula_b;
   logic [3:0] ula_op;
   logic       esc_reg, flag_imm, instr_done, halted;
   logic       is_imm, take_branch;

   assign is_imm      = (bus.opcode >= OP_IMM_LO);
   assign take_branch = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                        ((bus.opcode == OP_BNE) && !bus.zero);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      mem_req     = 1'b0;
      esc_ir      = 1'b0;
      esc_cp      = 1'b0;
      esc_cond_cp = 1'b0;
      fonte_cp    = 2'b00;
      ula_a       = 1'b0;
      ula_b       = 2'b00;
      ula_op      = 4'd0;
      esc_reg     = 1'b0;
      flag_imm    = 1'b0;
      instr_done  = 1'b0;
      halted      = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               esc_ir    = 1'b1;
               esc_cp    = 1'b1;
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            if (bus.opcode == OP_HALT)          state_nxt = HALT;
            else if (bus.opcode <= OP_LAST_ALU) state_nxt = EXEC;
            else if (bus.opcode == OP_BEQ ||
                     bus.opcode == OP_BNE)      state_nxt = BRANCH;
            else if (bus.opcode == OP_J)        state_nxt = JUMP;
            else if (bus.opcode == OP_NOP) begin
               instr_done = 1'b1;
               state_nxt  = FETCH;
            end
         end
         // WRITEBACK keeps the EXEC operand selects so the ALU result stays valid
         EXEC, WRITEBACK: begin
            ula_op   = bus.opcode;
            ula_b    = is_imm ? 2'b10 : 2'b00;
            flag_imm = is_imm;
            if (state == WRITEBACK) begin
               esc_reg    = 1'b1;
               instr_done = 1'b1;
               state_nxt  = FETCH;
            end else begin
               state_nxt  = WRITEBACK;
            end
         end
         BRANCH: begin
            ula_op      = OP_SUB;
            fonte_cp    = 2'b01;
            esc_cond_cp = take_branch;
            instr_done  = 1'b1;
            state_nxt   = FETCH;
         end
         JUMP: begin
            esc_cp     = 1'b1;
            fonte_cp   = 2'b10;
            instr_done = 1'b1;
            state_nxt  = FETCH;
         end
         HALT: halted = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.mem_req     = mem_req;
   assign bus.esc_ir      = esc_ir;
   assign bus.esc_cp      = esc_cp;
   assign bus.esc_cond_cp = esc_cond_cp;
   assign bus.fonte_cp    = fonte_cp;
   assign bus.ula_a       = ula_a;
   assign bus.ula_b       = ula_b;
   assign bus.ula_op      = ula_op;
   assign bus.esc_reg     = esc_reg;
   assign bus.flag_imm    = flag_imm;
   assign bus.instr_done  = instr_done;
   assign bus.halted      = halted;

`ifdef PERF_COUNTER_EN
   // Counters freeze in HALT; both wrap naturally at 16 bits
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         instr_count <= 16'd0;
         stall_count <= 16'd0;
      end else if (state != HALT) begin
         if (instr_done)                       instr_count <= instr_count + 16'd1;
         if (state == FETCH && !bus.mem_ready) stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_unidade_controle_fsm.sv
// Randomized self-checking bench: an instruction-level model expands each
// instruction into its expected per-cycle control vectors.
module tb_unidade_controle_fsm;

   typedef struct packed {
      logic       mem_req;
      logic       esc_ir;
      logic       esc_cp;
      logic       esc_cond_cp;
      logic [1:0] fonte_cp;
      logic       ula_a;
      logic [1:0] ula_b;
      logic [3:0] ula_op;
      logic       esc_reg;
      logic       flag_imm;
      logic       instr_done;
      logic       halted;
   } out_t;

   typedef struct packed {
      logic       mr;
      logic       z;
      logic [3:0] op;
      out_t       exp;
   } cyc_t;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b0;
   int   n_total  = 0;
   int   n_pass   = 0;

   cyc_t q[$];
   out_t obs[$];
   out_t exq[$];

   unidade_controle_fsm_if bus ();

`ifdef PERF_COUNTER_EN
   logic [15:0] instr_count, stall_count;
   unidade_controle_fsm dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus),
                             .instr_count(instr_count), .stall_count(stall_count));
`else
   unidade_controle_fsm dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));
`endif

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic out_t sample();
      out_t o;
      o.mem_req     = bus.mem_req;
      o.esc_ir      = bus.esc_ir;
      o.esc_cp      = bus.esc_cp;
      o.esc_cond_cp = bus.esc_cond_cp;
      o.fonte_cp    = bus.fonte_cp;
      o.ula_a       = bus.ula_a;
      o.ula_b       = bus.ula_b;
      o.ula_op      = bus.ula_op;
      o.esc_reg     = bus.esc_reg;
      o.flag_imm    = bus.flag_imm;
      o.instr_done  = bus.instr_done;
      o.halted      = bus.halted;
      return o;
   endfunction

   function automatic cyc_t noise();
      cyc_t c;
      c    = '0;
      c.mr = 1'($urandom_range(0, 1));
      c.z  = 1'($urandom_range(0, 1));
      c.op = 4'($urandom_range(0, 15));
      return c;
   endfunction

   // Expand one instruction into expected cycles, straight from the ISA rules
   task automatic add_instr(input logic [3:0] op, input int stalls, input logic z,
                            input int halt_n);
      cyc_t c;
      for (int i = 0; i < stalls; i++) begin
         c = noise(); c.mr = 1'b0; c.exp.mem_req = 1'b1;
         q.push_back(c);
      end
      c = noise(); c.mr = 1'b1;
      c.exp.mem_req = 1'b1; c.exp.esc_ir = 1'b1; c.exp.esc_cp = 1'b1;
      q.push_back(c);
      c = noise(); c.op = op; c.exp.instr_done = (op == 4'd14);
      q.push_back(c);
      if (op <= 4'd10) begin
         c = noise(); c.op = op;
         c.exp.ula_op   = op;
         c.exp.ula_b    = (op >= 4'd6) ? 2'b10 : 2'b00;
         c.exp.flag_imm = (op >= 4'd6);
         q.push_back(c);
         c.exp.esc_reg = 1'b1; c.exp.instr_done = 1'b1;
         q.push_back(c);
      end else if (op == 4'd11 || op == 4'd12) begin
         c = noise(); c.op = op; c.z = z;
         c.exp.ula_op      = 4'd1;
         c.exp.fonte_cp    = 2'b01;
         c.exp.esc_cond_cp = (op == 4'd11) ? z : !z;
         c.exp.instr_done  = 1'b1;
         q.push_back(c);
      end else if (op == 4'd13) begin
         c = noise();
         c.exp.esc_cp = 1'b1; c.exp.fonte_cp = 2'b10; c.exp.instr_done = 1'b1;
         q.push_back(c);
      end else if (op == 4'd15) begin
         for (int i = 0; i < halt_n; i++) begin
            c = noise(); c.exp.halted = 1'b1;
            q.push_back(c);
         end
      end
   endtask

   // Drives the queued cycles and records what the DUT showed at each negedge
   task automatic drive_all();
      cyc_t c;
      obs.delete(); exq.delete();
      while (q.size() > 0) begin
         c = q.pop_front();
         bus.mem_ready = c.mr;
         bus.zero      = c.z;
         bus.opcode    = c.op;
         @(negedge CLOCK_50);
         obs.push_back(sample());
         exq.push_back(c.exp);
         @(posedge CLOCK_50); #1;
      end
   endtask

   // Leaves the bench at posedge+1 with the FSM in its first FETCH cycle
   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #1 reset = 1'b1;
      @(posedge CLOCK_50); #1;
   endtask

   task automatic test_reset();
      bus.mem_ready = 1'b1; bus.zero = 1'b1; bus.opcode = 4'd0;
      reset = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #1;
      n_total++;
      if (sample() !== out_t'(0))
         $display("FAIL reset_hold got %h want %h", sample(), out_t'(0));
      else n_pass++;
      reset = 1'b1;
      @(negedge CLOCK_50);
      n_total++;
      if (sample() !== out_t'(0))
         $display("FAIL reset_idle got %h want %h", sample(), out_t'(0));
      else n_pass++;
      @(posedge CLOCK_50); #1;
      n_total++;
      if (bus.mem_req !== 1'b1)
         $display("FAIL reset_first_fetch mem_req got %b want 1", bus.mem_req);
      else n_pass++;
   endtask

   task automatic test_alu_basic();
      apply_reset();
      add_instr(4'd0, 0, 1'b0, 0);
      add_instr(4'd0, 0, 1'b0, 0);
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL alu_basic cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_stall_imm();
      add_instr(4'd7, 3, 1'b0, 0);
      add_instr(4'd10, 1, 1'b1, 0);
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL stall_imm cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_branch();
      add_instr(4'd11, 0, 1'b1, 0);
      add_instr(4'd11, 0, 1'b0, 0);
      add_instr(4'd12, 0, 1'b1, 0);
      add_instr(4'd12, 0, 1'b0, 0);
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL branch cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_jump_nop();
      add_instr(4'd13, 0, 1'b0, 0);
      add_instr(4'd14, 0, 1'b0, 0);
      add_instr(4'd14, 2, 1'b1, 0);
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL jump_nop cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++)
         add_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 0);
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL random cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_halt();
      add_instr(4'd3, 1, 1'b0, 0);
      add_instr(4'd15, 0, 1'b0, 12);
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL halt cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_wb();
      apply_reset();
      add_instr(4'd3, 0, 1'b0, 0);
      void'(q.pop_back());
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL mid_wb_pre cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
      // Now in WRITEBACK at posedge+1
      bus.opcode = 4'd3;
      #1;
      n_total++;
      if (bus.esc_reg !== 1'b1) $display("FAIL mid_wb_esc_reg got %b want 1", bus.esc_reg);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (sample() !== out_t'(0))
         $display("FAIL mid_wb_async got %h want %h", sample(), out_t'(0));
      else n_pass++;
      @(posedge CLOCK_50); #1;
      n_total++;
      if (sample() !== out_t'(0))
         $display("FAIL mid_wb_held got %h want %h", sample(), out_t'(0));
      else n_pass++;
      reset = 1'b1;
      @(posedge CLOCK_50); #1;
      add_instr(4'd8, 1, 1'b0, 0);
      drive_all();
      foreach (obs[i]) begin
         n_total++;
         if (obs[i] !== exq[i])
            $display("FAIL mid_wb_recover cyc %0d got %h want %h", i, obs[i], exq[i]);
         else n_pass++;
      end
   endtask

`ifdef PERF_COUNTER_EN
   task automatic test_perf();
      apply_reset();
      add_instr(4'd0, 1, 1'b0, 0);
      add_instr(4'd0, 0, 1'b0, 0);
      add_instr(4'd0, 1, 1'b0, 0);
      drive_all();
      n_total++;
      if (instr_count !== 16'd3) $display("FAIL perf_instr got %0d want 3", instr_count);
      else n_pass++;
      n_total++;
      if (stall_count !== 16'd2) $display("FAIL perf_stall got %0d want 2", stall_count);
      else n_pass++;
      add_instr(4'd15, 0, 1'b0, 5);
      drive_all();
      n_total++;
      if (instr_count !== 16'd3 || stall_count !== 16'd2)
         $display("FAIL perf_halt_freeze got %0d/%0d want 3/2", instr_count, stall_count);
      else n_pass++;
   endtask
`endif

   initial begin
      bus.mem_ready = 1'b0;
      bus.zero      = 1'b0;
      bus.opcode    = 4'd0;
      test_reset();
      test_alu_basic();
      test_stall_imm();
      test_branch();
      test_jump_nop();
      test_random();
      test_halt();
      test_reset_mid_wb();
`ifdef PERF_COUNTER_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
